// File: rtl/mandel_pixel_scheduler.sv
// mandel_pixel_scheduler: raster-scans a WIDTH x HEIGHT frame and hands pixel
// coordinates to NUM_ENGINES Mandelbrot point engines. Results come back out of
// order and leave on a valid/ready stream tagged with their (x, y).
// Build macro PERF_COUNT_EN adds the perf_cycles / perf_iter_sum counters.
//
// top state | meaning
// IDLE      | waiting for frame_start
// SCAN      | dispatching pixels in raster order
// DRAIN     | every pixel issued, waiting for slots and output register to empty
//
// slot state | meaning
// FREE       | engine idle, may receive a pixel
// ARMED      | start pulse out, engine done level is still stale this cycle
// RUN        | engine computing, waiting for eng_done
// HOLD       | result captured, waiting for the output register
module mandel_pixel_scheduler #(
  parameter int NUM_ENGINES = 4,
  parameter int HBI         = 32,
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       frame_start,
  output logic                       busy,
  output logic                       frame_done,
  output logic [NUM_ENGINES-1:0]     eng_start,
  output logic [12*NUM_ENGINES-1:0]  eng_x,
  output logic [12*NUM_ENGINES-1:0]  eng_y,
  input  logic [NUM_ENGINES-1:0]     eng_done,
  input  logic [HBI*NUM_ENGINES-1:0] eng_iter,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [11:0]                pix_x,
  output logic [11:0]                pix_y,
  output logic [HBI-1:0]             pix_iter
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0]                perf_cycles,
  output logic [47:0]                perf_iter_sum
`endif
);

  localparam int PW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [11:0] X_LAST = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(HEIGHT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} top_state_t;
  typedef enum logic [1:0] {SL_FREE, SL_ARMED, SL_RUN, SL_HOLD} slot_state_t;

  top_state_t  state, state_nxt;
  logic        frame_go, frame_end;
  slot_state_t slot [NUM_ENGINES];
  logic [11:0] tag_x [NUM_ENGINES];
  logic [11:0] tag_y [NUM_ENGINES];
  logic [HBI-1:0] res_iter [NUM_ENGINES];
  logic [11:0] scan_x, scan_y;
  logic [PW-1:0] disp_ptr, coll_ptr, disp_idx, coll_idx;
  logic disp_fire, coll_found, coll_fire, all_free, last_pixel;

  // Round-robin pointers never exceed NUM_ENGINES-1, so a single subtract wraps.
  function automatic logic [PW-1:0] wrap_idx(input int v);
    int r;
    r = (v >= NUM_ENGINES) ? v - NUM_ENGINES : v;
    return PW'(r);
  endfunction

  // Dispatch target: first FREE slot at or after the dispatch pointer, SCAN only.
  always_comb begin
    disp_fire = 1'b0;
    disp_idx  = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!disp_fire && slot[wrap_idx(int'(disp_ptr) + k)] == SL_FREE) begin
        disp_fire = 1'b1;
        disp_idx  = wrap_idx(int'(disp_ptr) + k);
      end
    end
    if (state != ST_SCAN) disp_fire = 1'b0;
  end

  // Collect source: first HOLD slot at or after the collect pointer.
  always_comb begin
    coll_found = 1'b0;
    coll_idx   = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!coll_found && slot[wrap_idx(int'(coll_ptr) + k)] == SL_HOLD) begin
        coll_found = 1'b1;
        coll_idx   = wrap_idx(int'(coll_ptr) + k);
      end
    end
    coll_fire = coll_found && (!pix_valid || pix_ready);
  end

  // Frame bookkeeping terms.
  always_comb begin
    all_free = 1'b1;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (slot[i] != SL_FREE) all_free = 1'b0;
    end
    last_pixel = (scan_x == X_LAST) && (scan_y == Y_LAST);
  end

  // Top FSM next state.
  always_comb begin
    state_nxt = state;
    frame_go  = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt = ST_SCAN;
          frame_go  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (disp_fire && last_pixel) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (all_free && !pix_valid) begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Top FSM state register with registered busy / frame_done.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= frame_end;
      if (frame_go)       busy <= 1'b1;
      else if (frame_end) busy <= 1'b0;
    end
  end

  // Raster scan counters advance once per dispatch.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (frame_go) begin
      scan_x <= '0;
      scan_y <= '0;
    end else if (disp_fire) begin
      if (scan_x == X_LAST) begin
        scan_x <= '0;
        scan_y <= (scan_y == Y_LAST) ? 12'd0 : scan_y + 12'd1;
      end else begin
        scan_x <= scan_x + 12'd1;
      end
    end
  end

  // Slot FSMs, engine start/coordinate outputs and round-robin pointers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      eng_start <= '0;
      eng_x     <= '0;
      eng_y     <= '0;
      disp_ptr  <= '0;
      coll_ptr  <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slot[i]     <= SL_FREE;
        tag_x[i]    <= '0;
        tag_y[i]    <= '0;
        res_iter[i] <= '0;
      end
    end else begin
      eng_start <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        case (slot[i])
          SL_FREE:  if (disp_fire && int'(disp_idx) == i) slot[i] <= SL_ARMED;
          SL_ARMED: slot[i] <= SL_RUN;
          SL_RUN: begin
            if (eng_done[i]) begin
              slot[i]     <= SL_HOLD;
              res_iter[i] <= eng_iter[HBI*i +: HBI];
            end
          end
          SL_HOLD:  if (coll_fire && int'(coll_idx) == i) slot[i] <= SL_FREE;
          default:  slot[i] <= SL_FREE;
        endcase
      end
      if (disp_fire) begin
        eng_start[disp_idx]              <= 1'b1;
        eng_x[12*int'(disp_idx) +: 12]   <= scan_x;
        eng_y[12*int'(disp_idx) +: 12]   <= scan_y;
        tag_x[disp_idx]                  <= scan_x;
        tag_y[disp_idx]                  <= scan_y;
        disp_ptr                         <= wrap_idx(int'(disp_idx) + 1);
      end
      if (coll_fire) coll_ptr <= wrap_idx(int'(coll_idx) + 1);
    end
  end

  // Output register: refills in the same cycle it is drained.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_iter  <= '0;
    end else if (coll_fire) begin
      pix_valid <= 1'b1;
      pix_x     <= tag_x[coll_idx];
      pix_y     <= tag_y[coll_idx];
      pix_iter  <= res_iter[coll_idx];
    end else if (pix_ready) begin
      pix_valid <= 1'b0;
    end
  end

`ifdef PERF_COUNT_EN
  logic [48:0] iter_sum_ext;
  assign iter_sum_ext = {1'b0, perf_iter_sum} + 49'(pix_iter);

  // Saturating frame performance counters, cleared when a frame is accepted.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perf_cycles   <= '0;
      perf_iter_sum <= '0;
    end else if (frame_go) begin
      perf_cycles   <= '0;
      perf_iter_sum <= '0;
    end else begin
      if (busy && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
      if (pix_valid && pix_ready)
        perf_iter_sum <= iter_sum_ext[48] ? 48'hFFFF_FFFF_FFFF : iter_sum_ext[47:0];
    end
  end
`endif

endmodule

// File: doc/mandel_pixel_scheduler.md
Name: mandel_pixel_scheduler

Overview:
- Scans a WIDTH x HEIGHT frame in raster order and feeds pixel coordinates to NUM_ENGINES Mandelbrot point generators.
- Each engine is driven by a start/done pair with the iteration result read back in parallel.
- Completed results go out on a valid/ready stream to the framebuffer writer, tagged with pixel coordinates.
- Sits between the frame-control logic (zoom/pan registers) and the engine array; scale and start values go directly to the engines and are not handled here.

Parameters:
- NUM_ENGINES, 4, number of point-generator engines, 1..16.
- HBI, 32, width of each engine's iteration result.
- WIDTH, 640, pixels per line, 1..4095.
- HEIGHT, 480, lines per frame, 1..4095.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel is accepted downstream.
- eng_start  out  NUM_ENGINES  per-engine one-cycle start pulse.
- eng_x  out  12*NUM_ENGINES  per-engine x coordinate, slice i = [12i+11:12i].
- eng_y  out  12*NUM_ENGINES  per-engine y coordinate.
- eng_done  in  NUM_ENGINES  per-engine done level.
- eng_iter  in  HBI*NUM_ENGINES  per-engine iteration count.
- pix_valid  out  1  result available.
- pix_ready  in  1  downstream accepts when high with pix_valid.
- pix_x  out  12  result x.
- pix_y  out  12  result y.
- pix_iter  out  HBI  result iteration count.

Behaviour:
- Reset (async, RST_N=0) values: all outputs 0, all slots FREE, scan counters 0, top state IDLE.
- Top FSM states:
  - IDLE: frame_start=1 -> SCAN; scan_x=scan_y=0, busy=1. frame_start while not IDLE is ignored.
  - SCAN: pixels are dispatched until (WIDTH-1, HEIGHT-1) is issued -> DRAIN.
  - DRAIN: all slots FREE and the output register empty -> frame_done pulse for 1 cycle, busy=0, IDLE.
- Per-engine slot FSM:
  - FREE -> ARMED on dispatch.
  - ARMED -> RUN on the next cycle. eng_done is ignored while ARMED, because the engine clears done only on the edge that samples start.
  - RUN with eng_done=1 -> HOLD; eng_iter is captured on that same edge.
  - HOLD -> FREE when its result is loaded into the output register.
- Dispatch:
  - At most one dispatch per cycle.
  - Target is the lowest-index FREE slot at or after the round-robin pointer; the pointer then advances to target+1 mod NUM_ENGINES.
  - On dispatch: eng_start[i] pulses for 1 cycle; eng_x/eng_y slice i is registered with scan_x/scan_y on the same edge and held until the next dispatch to slot i. The slot stores (x,y) as its tag.
  - Scan advance: x increments; at x=WIDTH-1, x wraps to 0 and y increments.
- Collection:
  - Output register loads when empty, or when emptied this cycle by pix_valid&&pix_ready (zero-bubble).
  - Source is one HOLD slot, chosen by a separate round-robin pointer.
  - Load latency: 1 cycle from HOLD to pix_valid.
- Output hold and ordering:
  - pix_x/pix_y/pix_iter are held stable while pix_valid=1 && pix_ready=0.
  - Results are out of raster order; the framebuffer addresses by tag.
- Simultaneous events:
  - Dispatch and collect on the same slot in one cycle: collect frees the slot, and the slot is dispatch-eligible only from the next cycle.
  - Dispatch and collect on different slots in the same cycle are both allowed.
- Backpressure: with pix_ready held 0, all slots reach HOLD and dispatch stalls. No result is dropped or duplicated.
- Reset mid-frame: everything returns to reset values immediately, and in-flight results are discarded. Engines still running are re-armed by their next start.

Optional Feature:
- Macro PERF_COUNT_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] and perf_iter_sum[47:0].
  - Both clear on an accepted frame_start.
  - perf_cycles increments every cycle while busy.
  - perf_iter_sum adds pix_iter on each accepted output.
  - Both saturate at all-ones and hold after frame_done.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- WIDTH=4, HEIGHT=2, NUM_ENGINES=4, engine model with fixed 5-cycle latency, pix_ready=1 -> 8 distinct (x,y) outputs covering (0..3, 0..1); frame_done 1 cycle after the 8th acceptance; busy falls on the same edge.
- Engine model whose done stays stale-high from a previous pixel for 1 cycle after start -> no premature capture; each pix_iter equals the model value for its own tag.
- Engine latency 3+x*7 cycles, NUM_ENGINES=2 -> out-of-order results with correct tags; per-engine eng_start never pulses while that slot is not FREE.
- pix_ready=0 for 50 cycles mid-frame -> pix_valid held with stable data, eng_start silent once all slots are in HOLD; on release, all 8 results appear exactly once.
- RST_N low for 1 cycle mid-SCAN, then frame_start -> outputs 0 during reset; the new frame starts at (0,0) and completes normally.
- PERF_COUNT_EN defined, engine returns iter=10 for all 8 pixels -> perf_iter_sum=80; perf_cycles equals the busy-high cycle count.
